// File: rtl/booth_div_pkg.sv
// Shared types and constants for the sequential signed divider.
package booth_div_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int DEF_WIDTH = 64;

    // Quotient reported when the divisor is zero
    localparam logic [DEF_WIDTH-1:0] DBZ_QUOT = '1;

endpackage

// File: rtl/booth_divider_div_step.sv
// One restoring-division iteration on unsigned magnitudes.
module div_step #(
    parameter int WIDTH = 64
) (
    input  logic [WIDTH-1:0] p_i,
    input  logic [WIDTH-1:0] q_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] p_o,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH:0] p_sh;
    logic [WIDTH:0] p_sub;

    assign p_sh  = {p_i, q_i[WIDTH-1]};
    assign p_sub = p_sh - {1'b0, d_i};

    // The restored value is always below D, so it fits in WIDTH bits
    always_comb begin
        if (p_sh >= {1'b0, d_i}) begin
            p_o = p_sub[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b1};
        end else begin
            p_o = p_sh[WIDTH-1:0];
            q_o = {q_i[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/booth_divider.sv
// Sequential signed divider: restoring division on magnitudes, then sign fix-up.
module booth_divider
    import booth_div_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CNT_W = 7
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_start,
    input  logic             op_clear,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             op_done,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   p_q, p_d, q_q, q_d, d_q, d_d;
    logic [WIDTH-1:0]   quot_q, quot_d, rem_q, rem_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               sq_q, sq_d, sr_q, sr_d;
    logic               done_q, done_d, busy_q, busy_d, dbz_q, dbz_d;
    logic [WIDTH-1:0]   p_nxt, q_nxt;

    div_step #(.WIDTH(WIDTH)) u_step (
        .p_i (p_q),
        .q_i (q_q),
        .d_i (d_q),
        .p_o (p_nxt),
        .q_o (q_nxt)
    );

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        q_d     = q_q;
        d_d     = d_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        cnt_d   = cnt_q;
        sq_d    = sq_q;
        sr_d    = sr_q;
        done_d  = done_q;
        busy_d  = busy_q;
        dbz_d   = dbz_q;

        if (op_clear) begin
            state_d = IDLE;
            p_d     = '0;
            q_d     = '0;
            d_d     = '0;
            quot_d  = '0;
            rem_d   = '0;
            cnt_d   = '0;
            sq_d    = 1'b0;
            sr_d    = 1'b0;
            done_d  = 1'b0;
            busy_d  = 1'b0;
            dbz_d   = 1'b0;
        end else if (op_start) begin
            p_d   = '0;
            cnt_d = '0;
            sq_d  = dividend[WIDTH-1] ^ divisor[WIDTH-1];
            sr_d  = dividend[WIDTH-1];
            if (divisor == '0) begin
                state_d = DONE;
                q_d     = '0;
                d_d     = '0;
                quot_d  = DBZ_QUOT[WIDTH-1:0];
                rem_d   = dividend;
                done_d  = 1'b1;
                busy_d  = 1'b0;
                dbz_d   = 1'b1;
            end else begin
                // Negating MIN wraps back to 2^(WIDTH-1), the correct unsigned magnitude
                state_d = BUSY;
                q_d     = dividend[WIDTH-1] ? -dividend : dividend;
                d_d     = divisor[WIDTH-1]  ? -divisor  : divisor;
                quot_d  = '0;
                rem_d   = '0;
                done_d  = 1'b0;
                busy_d  = 1'b1;
                dbz_d   = 1'b0;
            end
        end else begin
            case (state_q)
                BUSY: begin
                    p_d   = p_nxt;
                    q_d   = q_nxt;
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(WIDTH - 1)) state_d = FIX;
                end
                FIX: begin
                    quot_d  = sq_q ? -q_q : q_q;
                    rem_d   = sr_q ? -p_q : p_q;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = DONE;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            p_q     <= '0;
            q_q     <= '0;
            d_q     <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            cnt_q   <= '0;
            sq_q    <= 1'b0;
            sr_q    <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            q_q     <= q_d;
            d_q     <= d_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            cnt_q   <= cnt_d;
            sq_q    <= sq_d;
            sr_q    <= sr_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            dbz_q   <= dbz_d;
        end
    end

    assign op_done     = done_q;
    assign busy        = busy_q;
    assign quotient    = quot_q;
    assign remainder   = rem_q;
    assign div_by_zero = dbz_q;

endmodule

// File: doc/booth_divider.md
Name: booth_divider

Overview:
- Sequential signed integer divider, the inverse counterpart of the radix-4 Booth multiplier in the arithmetic datapath.
- Computes quotient and remainder of two WIDTH-bit two's-complement operands using radix-2 restoring division on magnitudes, then applies a sign fix-up.
- Uses the same op_start / op_clear / op_done handshake as the multiplier, so the multiplier and divider are interchangeable behind one bus-slave wrapper.

Parameters:
- WIDTH, 64, operand/result width in bits.
- CNT_W, 7, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- op_start  input  1  load operands and begin division.
- op_clear  input  1  abort and clear to logical zero.
- dividend  input  WIDTH  signed dividend, sampled on the start edge.
- divisor  input  WIDTH  signed divisor, sampled on the start edge.
- op_done  output  1  result valid; held until clear or restart.
- busy  output  1  division in progress.
- quotient  output  WIDTH  signed quotient, truncated toward zero.
- remainder  output  WIDTH  signed remainder; sign follows the dividend.
- div_by_zero  output  1  set with op_done when divisor was 0.

Behaviour:
- One clock; reset is synchronous and active-high.
- Reset (reset=1 at an edge): state=IDLE, op_done=0, busy=0, quotient=0, remainder=0, div_by_zero=0, counter=0, internal registers=0. Reset overrides everything, including mid-operation.
- Control priority at each edge: reset > op_clear > op_start > FSM advance.
- op_clear=1 in any state: same values as reset (logical zero), state=IDLE. op_clear takes priority when op_start is also 1.
- op_start=1, op_clear=0, divisor!=0, in any state:
  - Latch |dividend| and |divisor| (unsigned WIDTH-bit magnitudes, so |MIN| = 2^(WIDTH-1)).
  - Record sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - counter=0, partial remainder=0, state=BUSY, busy=1, op_done=0, quotient=0, remainder=0, div_by_zero=0.
  - Holding op_start high reloads on every edge; no progress is made.
- op_start=1, op_clear=0, divisor==0: state=DONE, op_done=1, div_by_zero=1, quotient=all ones, remainder=dividend. Latency is 1 edge.
- BUSY, one iteration per edge (op_start=0, op_clear=0):
  - P' = {P[WIDTH-1:0], Q[MSB]}, a WIDTH+1-bit value.
  - Q shifts left by 1.
  - If P' >= D: P = P' - D and Q[0] = 1; else P = P' and Q[0] = 0.
  - counter increments. After WIDTH iterations (counter==WIDTH-1 at the edge), state=FIX.
- FIX, one edge:
  - quotient = sign_q ? -Q : Q.
  - remainder = sign_r ? -P[WIDTH-1:0] : P[WIDTH-1:0].
  - state=DONE, op_done=1, busy=0.
- DONE: outputs and op_done hold until op_clear, op_start, or reset.
- Latency from the start edge to op_done visible is WIDTH+2 edges (66 at default).
- Overflow case MIN / -1: quotient=MIN, remainder=0, no flag. This is natural wrap with no special case.
- Outputs are registered. quotient and remainder read 0 while BUSY and update only on the FIX edge.

Decomposition:
- Package booth_div_pkg holds:
  - state enum: IDLE, BUSY, FIX, DONE.
  - WIDTH default.
  - Constant for the divide-by-zero quotient (all ones).
- One combinational sub-module, div_step: inputs P, Q, D; outputs next P and next Q for one restoring iteration. Instantiated once in the top FSM.

Test Plan:
- reset then dividend=100, divisor=7, op_start pulse for 1 cycle -> busy=1; op_done=1 exactly 66 edges after the start edge; quotient=14, remainder=2, div_by_zero=0; values held 10 further cycles.
- Signs: -100/7 -> quotient=-14, remainder=-2. 100/-7 -> quotient=-14, remainder=2. -100/-7 -> quotient=14, remainder=-2.
- Boundaries:
  - 0x8000000000000000 / -1 -> quotient=0x8000000000000000, remainder=0.
  - 0x8000000000000000 / 1 -> quotient=0x8000000000000000, remainder=0.
  - 5/9 -> quotient=0, remainder=5.
- 5/0 -> op_done=1 and div_by_zero=1 one edge after start; quotient=0xFFFFFFFFFFFFFFFF, remainder=5; no BUSY cycles.
- Abort mid-operation:
  - op_clear at iteration 30 -> next edge all outputs 0, busy=0, state IDLE; a new start of 81/9 then yields quotient=9, remainder=0.
  - op_start and op_clear both high -> clear wins.
- reset asserted in the BUSY state and in the DONE state -> next edge all outputs 0; op_start re-asserted during BUSY restarts, with 66-edge latency measured from the new start edge.
